// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the digital clock sequencer.
//
// Contents:
//   MODE_W  - width of the state / display mode code
//   FIELD_W - width of the seconds and minutes counter values
//   state_t - sequencer states; the encoding is also the mode code
//             presented to the display mux (ST_SET_AL_* are only
//             reachable when ALARM_EDIT_EN is defined)
package clock_ctrl_pkg;

    localparam int MODE_W  = 3;
    localparam int FIELD_W = 6;

    typedef enum logic [MODE_W-1:0] {
        ST_RUN        = 3'd0,
        ST_SET_HR     = 3'd1,
        ST_SET_MIN    = 3'd2,
        ST_SET_SEC    = 3'd3,
        ST_SET_AL_HR  = 3'd4,
        ST_SET_AL_MIN = 3'd5
    } state_t;

endpackage

// File: rtl/clock_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV enabled cycles.
//
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high reset (count to 0)
//   en    - count enable; tick is only produced while enabled
//   clr   - synchronous clear, overrides en
//   tick  - high for the single cycle in which count == DIV-1
module clock_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = en & (count == LAST);

endmodule

// File: rtl/clock_set_ctrl.sv
// Sequencer for the seconds / minutes / hours counters of the digital clock.
// In RUN it produces the 1 Hz tick and the sec -> min -> hr carry chain; in
// the SET modes timekeeping is frozen and the selected field is stepped up or
// down from the debounced buttons. All outputs are registered; enables are
// one-cycle pulses the cycle after the causing event.
//
// Optional build macro: ALARM_EDIT_EN adds the SET_AL_HR / SET_AL_MIN states
// (mode 4 / 5) and the al_hr_en / al_min_en outputs.
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   btn_mode              - advance edit mode (wins over up/down)
//   btn_up, btn_down      - step selected field up / down (both = no action)
//   sec_count, min_count  - current counter values, read on the tick cycle
//   sec_en, min_en, hr_en - counter enables
//   inc_dec               - 0 count up, 1 count down (shared)
//   mode                  - current state code for the display mux
//   blink_on              - display enable for the field being edited
//   al_hr_en, al_min_en   - alarm counter enables (ALARM_EDIT_EN only)
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = 100000000,
    parameter int BLINK_DIV = 25000000,
    parameter int SEC_N     = 60,
    parameter int MIN_N     = 60,
    parameter int HR_N      = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_mode,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic [FIELD_W-1:0] sec_count,
    input  logic [FIELD_W-1:0] min_count,
    output logic               sec_en,
    output logic               min_en,
    output logic               hr_en,
    output logic               inc_dec,
    output logic [MODE_W-1:0]  mode,
    output logic               blink_on
`ifdef ALARM_EDIT_EN
    ,
    output logic               al_hr_en,
    output logic               al_min_en
`endif
);

    if (TICK_DIV < 4 || BLINK_DIV < 2 || SEC_N > 64 || MIN_N > 64 || HR_N > 64) begin : g_bad_params
        $error("clock_set_ctrl: parameter out of range");
    end

    state_t state, next_state;
    logic   tick, blink_tick, state_change, step;
    logic   sec_en_d, min_en_d, hr_en_d, inc_dec_d;
`ifdef ALARM_EDIT_EN
    logic   al_hr_en_d, al_min_en_d;
`endif

    // Exactly one of up/down pressed; both together cancel out.
    assign step         = btn_up ^ btn_down;
    assign state_change = (next_state != state);

    // 1 Hz prescaler: runs only in RUN and restarts from 0 whenever RUN is
    // (re)entered, so the first tick lands TICK_DIV cycles after entry.
    clock_tick_gen #(.DIV(TICK_DIV)) u_sec_tick (
        .clk   (clk),
        .reset (reset),
        .en    (state == ST_RUN),
        .clr   ((state != ST_RUN) | state_change),
        .tick  (tick)
    );

    // Blink phase divider: restarts on every state change.
    clock_tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
        .clk   (clk),
        .reset (reset),
        .en    (state != ST_RUN),
        .clr   (state_change),
        .tick  (blink_tick)
    );

    always_comb begin
        next_state = state;
        sec_en_d   = 1'b0;
        min_en_d   = 1'b0;
        hr_en_d    = 1'b0;
        inc_dec_d  = 1'b0;
`ifdef ALARM_EDIT_EN
        al_hr_en_d  = 1'b0;
        al_min_en_d = 1'b0;
`endif
        case (state)
            ST_RUN: begin
                // Timekeeping continues on the cycle btn_mode is taken.
                sec_en_d = tick;
                min_en_d = tick & (sec_count == FIELD_W'(SEC_N - 1));
                hr_en_d  = min_en_d & (min_count == FIELD_W'(MIN_N - 1));
                if (btn_mode) next_state = ST_SET_HR;
            end
            ST_SET_HR: begin
                if (btn_mode) next_state = ST_SET_MIN;
                else if (step) begin
                    hr_en_d   = 1'b1;
                    inc_dec_d = btn_down;
                end
            end
            ST_SET_MIN: begin
                if (btn_mode) next_state = ST_SET_SEC;
                else if (step) begin
                    min_en_d  = 1'b1;
                    inc_dec_d = btn_down;
                end
            end
            ST_SET_SEC: begin
`ifdef ALARM_EDIT_EN
                if (btn_mode) next_state = ST_SET_AL_HR;
`else
                if (btn_mode) next_state = ST_RUN;
`endif
                else if (step) begin
                    sec_en_d  = 1'b1;
                    inc_dec_d = btn_down;
                end
            end
`ifdef ALARM_EDIT_EN
            ST_SET_AL_HR: begin
                if (btn_mode) next_state = ST_SET_AL_MIN;
                else if (step) begin
                    al_hr_en_d = 1'b1;
                    inc_dec_d  = btn_down;
                end
            end
            ST_SET_AL_MIN: begin
                if (btn_mode) next_state = ST_RUN;
                else if (step) begin
                    al_min_en_d = 1'b1;
                    inc_dec_d   = btn_down;
                end
            end
`endif
            default: next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            sec_en    <= 1'b0;
            min_en    <= 1'b0;
            hr_en     <= 1'b0;
            inc_dec   <= 1'b0;
            blink_on  <= 1'b1;
`ifdef ALARM_EDIT_EN
            al_hr_en  <= 1'b0;
            al_min_en <= 1'b0;
`endif
        end else begin
            state   <= next_state;
            sec_en  <= sec_en_d;
            min_en  <= min_en_d;
            hr_en   <= hr_en_d;
            inc_dec <= inc_dec_d;
`ifdef ALARM_EDIT_EN
            al_hr_en  <= al_hr_en_d;
            al_min_en <= al_min_en_d;
`endif
            if (state_change || state == ST_RUN) blink_on <= 1'b1;
            else if (blink_tick)                 blink_on <= ~blink_on;
        end
    end

    // The state register doubles as the registered mode code.
    assign mode = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

    localparam int TICK_DIV  = 10;
    localparam int BLINK_DIV = 4;
    localparam int SEC_N     = 60;
    localparam int MIN_N     = 60;
`ifdef ALARM_EDIT_EN
    localparam int N_MODES = 6;
    localparam int OW      = 10;
`else
    localparam int N_MODES = 4;
    localparam int OW      = 8;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_up, btn_down;
    logic [5:0] sec_count, min_count;
    logic       sec_en, min_en, hr_en, inc_dec, blink_on;
    logic [2:0] mode;
    logic [OW-1:0] obs;
`ifdef ALARM_EDIT_EN
    logic       al_hr_en, al_min_en;
    assign obs = {sec_en, min_en, hr_en, inc_dec, mode, blink_on, al_hr_en, al_min_en};
    localparam logic [OW-1:0] RST_V = 10'b0000_000_1_00;
`else
    assign obs = {sec_en, min_en, hr_en, inc_dec, mode, blink_on};
    localparam logic [OW-1:0] RST_V = 8'b0000_000_1;
`endif

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .TICK_DIV (TICK_DIV),
        .BLINK_DIV(BLINK_DIV),
        .SEC_N    (SEC_N),
        .MIN_N    (MIN_N),
        .HR_N     (24)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .sec_count (sec_count),
        .min_count (min_count),
        .sec_en    (sec_en),
        .min_en    (min_en),
        .hr_en     (hr_en),
        .inc_dec   (inc_dec),
        .mode      (mode),
        .blink_on  (blink_on)
`ifdef ALARM_EDIT_EN
        ,
        .al_hr_en  (al_hr_en),
        .al_min_en (al_min_en)
`endif
    );

    // ---------------- reference model / scoreboard ----------------
    // Model state: current mode number, cycles spent in the current mode,
    // and cycles spent in RUN since it was last entered.
    int m_mode, m_phase, m_run;
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] exp_v;
    int n_vec = 0;
    int n_err = 0;

    task automatic model_reset();
        m_mode  = 0;
        m_phase = 0;
        m_run   = 0;
        exp_q.delete();
    endtask

    // Predicts the outputs visible after the coming clock edge.
    task automatic model_step(input logic bm, input logic bu, input logic bd,
                              input logic [5:0] sc, input logic [5:0] mc);
        logic s_e, mi_e, h_e, id, bl, ah, am;
        int   nm;
        s_e = 0; mi_e = 0; h_e = 0; id = 0; ah = 0; am = 0;
        if (m_mode == 0) begin
            s_e  = ((m_run % TICK_DIV) == TICK_DIV - 1);
            mi_e = s_e && (int'(sc) == SEC_N - 1);
            h_e  = mi_e && (int'(mc) == MIN_N - 1);
        end else if (!bm && (bu != bd)) begin
            id = bd;
            case (m_mode)
                1: h_e  = 1;
                2: mi_e = 1;
                3: s_e  = 1;
                4: ah   = 1;
                default: am = 1;
            endcase
        end
        nm = bm ? (m_mode + 1) % N_MODES : m_mode;
        if (nm != m_mode) begin
            m_run   = 0;
            m_phase = 0;
        end else begin
            m_run++;
            m_phase++;
        end
        m_mode = nm;
        bl = (m_mode == 0) ? 1'b1 : (((m_phase / BLINK_DIV) % 2) == 0);
`ifdef ALARM_EDIT_EN
        exp_q.push_back({s_e, mi_e, h_e, id, 3'(m_mode), bl, ah, am});
`else
        exp_q.push_back({s_e, mi_e, h_e, id, 3'(m_mode), bl});
`endif
    endtask

    // ---------------- driver ----------------
    // Called #1 after a rising edge; applies one cycle of stimulus.
    task automatic drive(input logic bm, input logic bu, input logic bd,
                         input logic [5:0] sc, input logic [5:0] mc);
        btn_mode  = bm;
        btn_up    = bu;
        btn_down  = bd;
        sec_count = sc;
        min_count = mc;
        model_step(bm, bu, bd, sc, mc);
        @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int first_tick;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (obs !== RST_V) begin
            n_err++;
            $display("FAIL reset_state: got %b exp %b", obs, RST_V);
        end
        reset = 1'b0;
        model_reset();
        first_tick = -1;
        for (int i = 1; i <= 12; i++) begin
            drive(0, 0, 0, 6'd5, 6'd5);
            exp_v = exp_q.pop_front();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL reset_run c%0d: got %b exp %b", i, obs, exp_v);
            end
            if (first_tick < 0 && sec_en) first_tick = i;
        end
        n_vec++;
        if (first_tick != TICK_DIV) begin
            n_err++;
            $display("FAIL first_tick: got %0d exp %0d", first_tick, TICK_DIV);
        end
    endtask

    task automatic test_carry();
        for (int i = 0; i < 40; i++) begin
            drive(0, 0, 0, 6'd59, (i < 20) ? 6'd59 : 6'd12);
            exp_v = exp_q.pop_front();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL carry c%0d: got %b exp %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_set_hr_freeze();
        drive(1, 0, 0, 6'd59, 6'd59);
        exp_v = exp_q.pop_front();
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL enter_set_hr: got %b exp %b", obs, exp_v);
        end
        drive(0, 0, 1, 6'd59, 6'd59);
        exp_v = exp_q.pop_front();
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL hr_down: got %b exp %b", obs, exp_v);
        end
        for (int i = 0; i < 50; i++) begin
            drive(0, 0, 0, 6'd59, 6'd59);
            exp_v = exp_q.pop_front();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL frozen c%0d: got %b exp %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_set_min_conflict();
        drive(1, 0, 0, 6'd0, 6'd0);   // -> SET_MIN
        drive(0, 1, 1, 6'd0, 6'd0);   // up+down: nothing
        drive(0, 0, 0, 6'd0, 6'd0);
        drive(1, 1, 0, 6'd0, 6'd0);   // mode wins over up -> SET_SEC
        for (int i = 0; i < 4; i++) begin
            exp_v = exp_q.pop_front();
            n_vec++;
        end
        // Only the last prediction is still comparable to the live outputs.
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL mode_over_up: got %b exp %b", obs, exp_v);
        end
    endtask

    task automatic test_blink_exit();
        for (int i = 0; i < 13; i++) begin
            drive(0, 0, 0, 6'd30, 6'd30);
            exp_v = exp_q.pop_front();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL blink c%0d: got %b exp %b", i, obs, exp_v);
            end
        end
`ifdef ALARM_EDIT_EN
        drive(1, 0, 0, 6'd30, 6'd30);
        void'(exp_q.pop_front());
        drive(1, 0, 0, 6'd30, 6'd30);
        void'(exp_q.pop_front());
`endif
        for (int i = 0; i <= TICK_DIV + 1; i++) begin
            drive(i == 0, 0, 0, 6'd30, 6'd30);
            exp_v = exp_q.pop_front();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL exit_run c%0d: got %b exp %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 0, 6'd0, 6'd0);
        drive(1, 0, 0, 6'd0, 6'd0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        for (int i = 0; i < 8; i++) begin
            drive(0, i[0] == 0, i[0] == 1, 6'd0, 6'd0);
            exp_v = exp_q.pop_front();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL b2b c%0d: got %b exp %b", i, obs, exp_v);
            end
        end
    endtask

`ifdef ALARM_EDIT_EN
    task automatic test_alarm();
        while (m_mode != 3) begin
            drive(1, 0, 0, 6'd0, 6'd0);
            void'(exp_q.pop_front());
        end
        drive(1, 0, 0, 6'd0, 6'd0);
        drive(0, 1, 0, 6'd0, 6'd0);
        drive(1, 0, 0, 6'd0, 6'd0);
        drive(1, 0, 0, 6'd0, 6'd0);
        for (int i = 0; i < 4; i++) begin
            exp_v = exp_q.pop_front();
        end
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL alarm_back_to_run: got %b exp %b", obs, exp_v);
        end
    endtask
`endif

    task automatic test_random();
        logic [5:0] sc, mc;
        logic bm;
        for (int i = 0; i < 500; i++) begin
            sc = ($urandom_range(0, 1) == 1) ? 6'd59 : 6'($urandom_range(0, 59));
            mc = ($urandom_range(0, 1) == 1) ? 6'd59 : 6'($urandom_range(0, 59));
            bm = ($urandom_range(0, 15) == 0);
            drive(bm, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, sc, mc);
            exp_v = exp_q.pop_front();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL random c%0d: got %b exp %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 6'd0, 6'd0);
        drive(0, 1, 0, 6'd0, 6'd0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (obs !== RST_V) begin
            n_err++;
            $display("FAIL async_reset: got %b exp %b", obs, RST_V);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < TICK_DIV + 2; i++) begin
            drive(0, 1, 0, 6'd59, 6'd59);
            exp_v = exp_q.pop_front();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL post_reset c%0d: got %b exp %b", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        btn_mode  = 1'b0;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        sec_count = '0;
        min_count = '0;
        test_reset();
        test_carry();
        test_set_hr_freeze();
        test_set_min_conflict();
        test_blink_exit();
        test_back_to_back();
`ifdef ALARM_EDIT_EN
        test_reset_mid();
        test_alarm();
`endif
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
